// File: rtl/alu_ctr.sv
// ALU control decoder.
// Translates the main-control operation class (ALUop) and the R-type funct
// field (Func) into the 3-bit ALU operation select. Both outputs are
// registered so the select lines up with the ID/EX pipeline boundary.
// A low 'en' stalls the stage, and the synchronous reset always wins.
module alu_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] ALUop,
    input  logic [5:0] Func,
    output logic [2:0] ALUoper,
    output logic       illegal
);

    // ALU operation select encodings (3'b101 is reserved and never produced)
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Operation classes from the main control unit
    localparam logic [1:0] CLS_MEM   = 2'b00;  // lw/sw/addi
    localparam logic [1:0] CLS_BR    = 2'b01;  // beq/bne
    localparam logic [1:0] CLS_RTYPE = 2'b10;  // decode funct
    localparam logic [1:0] CLS_LOGI  = 2'b11;  // ori / logical immediate

    // Supported R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    logic [2:0] oper_s;
    logic       illegal_s;
    logic [2:0] oper_r;
    logic       illegal_r;

    // Combinational decode of the current class/funct into the next select value
    always_comb begin
        oper_s    = OP_ADD;
        illegal_s = 1'b0;
        case (ALUop)
            CLS_MEM: begin
                oper_s    = OP_ADD;
                illegal_s = 1'b0;
            end
            CLS_BR: begin
                oper_s    = OP_SUB;
                illegal_s = 1'b0;
            end
            CLS_LOGI: begin
                oper_s    = OP_OR;
                illegal_s = 1'b0;
            end
            CLS_RTYPE: begin
                case (Func)
                    FN_ADD,
                    FN_ADDU: oper_s = OP_ADD;
                    FN_SUB,
                    FN_SUBU: oper_s = OP_SUB;
                    FN_AND:  oper_s = OP_AND;
                    FN_OR:   oper_s = OP_OR;
                    FN_XOR:  oper_s = OP_XOR;
                    FN_NOR:  oper_s = OP_NOR;
                    FN_SLT,
                    FN_SLTU: oper_s = OP_SLT;
                    default: begin
                        // Unsupported funct (including sll/nop): fall back to ADD and flag it
                        oper_s    = OP_ADD;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            default: begin
                oper_s    = OP_ADD;
                illegal_s = 1'b0;
            end
        endcase
    end

    // Pipeline register: reset to ADD, load on enable, otherwise hold (stall)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oper_r    <= OP_ADD;
            illegal_r <= 1'b0;
        end else if (en) begin
            oper_r    <= oper_s;
            illegal_r <= illegal_s;
        end else begin
            oper_r    <= oper_r;
            illegal_r <= illegal_r;
        end
    end

    assign ALUoper = oper_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_alu_ctr.sv
// Self-checking bench for alu_ctr: directed steps from the test plan followed
// by randomized traffic, all checked against a table-driven reference model.
module tb_alu_ctr;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] ALUop;
    logic [5:0] Func;
    logic [2:0] ALUoper;
    logic       illegal;

    int tests_run;
    int tests_failed;

    // Reference model state: what the registered outputs should hold
    logic [2:0] exp_oper;
    logic       exp_ill;

    // Supported R-type funct table and the select each one produces
    logic [5:0] fn_tab [10];
    logic [2:0] op_tab [10];

    alu_ctr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .ALUop   (ALUop),
        .Func    (Func),
        .ALUoper (ALUoper),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: class rules, then a table lookup for R-type
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
        logic [3:0] r;
        r = {3'd2, 1'b0};
        if (op == 2'd0) r = {3'd2, 1'b0};
        else if (op == 2'd1) r = {3'd6, 1'b0};
        else if (op == 2'd3) r = {3'd1, 1'b0};
        else begin
            r = {3'd2, 1'b1};
            for (int i = 0; i < 10; i++)
                if (fn_tab[i] == fn) r = {op_tab[i], 1'b0};
        end
        return r;
    endfunction

    task automatic check(input string tag);
        tests_run++;
        assert (ALUoper === exp_oper) else begin
            tests_failed++;
            $error("FAIL %s ALUoper observed=%b expected=%b", tag, ALUoper, exp_oper);
        end
        tests_run++;
        assert (illegal === exp_ill) else begin
            tests_failed++;
            $error("FAIL %s illegal observed=%b expected=%b", tag, illegal, exp_ill);
        end
    endtask

    // Apply inputs away from the edge, clock once, advance the model, check
    task automatic step(input logic r, input logic e, input logic [1:0] op,
                        input logic [5:0] fn, input string tag);
        logic [3:0] d;
        rst_n = r;
        en    = e;
        ALUop = op;
        Func  = fn;
        @(posedge clk);
        d = ref_decode(op, fn);
        if (!r) begin
            exp_oper = 3'd2;
            exp_ill  = 1'b0;
        end else if (e) begin
            exp_oper = d[3:1];
            exp_ill  = d[0];
        end
        #1;
        check(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        op_tab = '{3'd2, 3'd2, 3'd6, 3'd6, 3'd0, 3'd1, 3'd3, 3'd4, 3'd7, 3'd7};
        exp_oper = 3'd2;
        exp_ill  = 1'b0;
        rst_n = 1'b0; en = 1'b1; ALUop = 2'b01; Func = 6'h00;
        #2;

        // Reset for two edges, then release
        step(1'b0, 1'b1, 2'b01, 6'h00, "reset0");
        step(1'b0, 1'b1, 2'b01, 6'h00, "reset1");
        step(1'b1, 1'b1, 2'b01, 6'h00, "release");

        // Non-R classes with a funct that would decode as slt
        step(1'b1, 1'b1, 2'b00, 6'h2A, "cls00");
        step(1'b1, 1'b1, 2'b01, 6'h2A, "cls01");
        step(1'b1, 1'b1, 2'b11, 6'h2A, "cls11");

        // No combinational path: change inputs mid-cycle, outputs must not move
        ALUop = 2'b10; Func = 6'h27;
        #2;
        check("nocomb");

        // R-type sweep in consecutive cycles
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 2'b10, fn_tab[i], $sformatf("rsweep_%0h", fn_tab[i]));

        // Unsupported funct codes, then back to a non-R class
        step(1'b1, 1'b1, 2'b10, 6'h00, "ill_00");
        step(1'b1, 1'b1, 2'b10, 6'h08, "ill_08");
        step(1'b1, 1'b1, 2'b10, 6'h3F, "ill_3f");
        step(1'b1, 1'b1, 2'b00, 6'h3F, "ill_clear");

        // Stall holds the last loaded decode
        step(1'b1, 1'b1, 2'b10, 6'h22, "stall_load");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 2'b10, 6'h24, $sformatf("stall_hold%0d", i));
        step(1'b1, 1'b1, 2'b10, 6'h24, "stall_release");

        // Reset applies even while stalled
        step(1'b1, 1'b1, 2'b10, 6'h22, "rstall_load");
        step(1'b1, 1'b0, 2'b10, 6'h24, "rstall_hold");
        step(1'b0, 1'b0, 2'b10, 6'h24, "rstall_reset");
        step(1'b1, 1'b0, 2'b10, 6'h3F, "rstall_after");

        // Randomized traffic, biased toward R-type and enabled cycles
        for (int i = 0; i < 400; i++) begin
            logic       r, e;
            logic [1:0] op;
            logic [5:0] fn;
            r  = ($urandom_range(0, 19) != 0);
            e  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) fn = fn_tab[$urandom_range(0, 9)];
            else fn = 6'($urandom_range(0, 63));
            step(r, e, op, fn, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
